// File: rtl/seq_detect_arbiter.sv
// Round-robin front end sharing one overlapping "111" serial detector among N word producers.
// Each granted word is shifted MSB-first; the number of matches is reported with a done pulse.
module seq_detect_arbiter #(
  parameter int N = 4,
  parameter int W = 16,
  localparam int IDW = $clog2(N),
  localparam int CW  = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [CW-1:0]    match_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } det_t;

  state_t           state_r;
  det_t             det_r;
  det_t             det_nx_s;
  logic [W-1:0]     shreg_r;
  logic [CW-1:0]    bitcnt_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   sel_r;
  logic [IDW-1:0]   sel_s;
  logic [IDW-1:0]   idx_s;
  logic             hit_s;
  logic             bit_s;
  logic [N-1:0]     gnt_r;
  logic             busy_r;
  logic             done_r;
  logic [IDW-1:0]   done_id_r;
  logic [CW-1:0]    match_cnt_r;

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign match_cnt = match_cnt_r;
  assign state     = state_r;

  // Round-robin search: first requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    sel_s = '0;
    hit_s = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % N);
      sel_s = (!hit_s && req[idx_s]) ? idx_s : sel_s;
      hit_s = hit_s | req[idx_s];
    end
  end

  // Moore detector next state and running count for the bit being consumed.
  always_comb begin
    bit_s    = shreg_r[W-1];
    det_nx_s = D0;
    case (det_r)
      D0:      det_nx_s = bit_s ? D1 : D0;
      D1:      det_nx_s = bit_s ? D2 : D0;
      D2:      det_nx_s = bit_s ? D3 : D0;
      D3:      det_nx_s = bit_s ? D3 : D0;
      default: det_nx_s = D0;
    endcase
    cnt_nx_s = (bit_s && (det_r == D2 || det_r == D3)) ? cnt_r + CW'(1) : cnt_r;
  end

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      det_r       <= D0;
      shreg_r     <= '0;
      bitcnt_r    <= '0;
      cnt_r       <= '0;
      ptr_r       <= '0;
      sel_r       <= '0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= '0;
      match_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (hit_s) begin
            shreg_r  <= data[int'(sel_s)*W +: W];
            gnt_r    <= {{(N-1){1'b0}}, 1'b1} << sel_s;
            sel_r    <= sel_s;
            det_r    <= D0;
            cnt_r    <= '0;
            bitcnt_r <= '0;
            ptr_r    <= (sel_s == IDW'(N-1)) ? '0 : sel_s + IDW'(1);
            state_r  <= SHIFT;
            busy_r   <= 1'b1;
          end else begin
            gnt_r    <= '0;
            state_r  <= IDLE;
            busy_r   <= 1'b0;
          end
        end
        SHIFT: begin
          gnt_r    <= '0;
          shreg_r  <= {shreg_r[W-2:0], 1'b0};
          det_r    <= det_nx_s;
          cnt_r    <= cnt_nx_s;
          bitcnt_r <= bitcnt_r + CW'(1);
          // The last bit's contribution is taken from cnt_nx_s so it is not lost.
          if (bitcnt_r == CW'(W-1)) begin
            state_r     <= DONE;
            done_r      <= 1'b1;
            match_cnt_r <= cnt_nx_s;
            done_id_r   <= sel_r;
          end else begin
            state_r     <= SHIFT;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
